// File: rtl/r2mdc_commutator.sv
`default_nettype none
// ============================================================================
// Module   : r2mdc_commutator
// Brief    : Radix-2 MDC inter-stage delay commutator with self-draining flush.
// Revision : 1.0 - initial release
// ============================================================================
module r2mdc_commutator #(
    parameter int BIT_LEN = 14,
    parameter int DELAY   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               last_in,
    input  logic [BIT_LEN-1:0] A_in,
    input  logic [BIT_LEN-1:0] B_in,
    output logic               ready_out,
    output logic [BIT_LEN-1:0] A_out,
    output logic [BIT_LEN-1:0] B_out,
    output logic               valid_out,
    output logic               last_out
);

    localparam int c_CW = (DELAY > 1) ? $clog2(2 * DELAY) : 1;
    localparam int c_SB = (DELAY > 1) ? $clog2(DELAY) : 0;

    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(2 * DELAY - 1);
    localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'(DELAY - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_first;
    logic [BIT_LEN-1:0] r_bdl [DELAY];
    logic [BIT_LEN-1:0] r_xdl [DELAY];

    logic               w_step;
    logic               w_frame_end;
    logic               w_sel;
    logic               w_prime;
    logic [BIT_LEN-1:0] w_a;
    logic [BIT_LEN-1:0] w_b;
    logic [BIT_LEN-1:0] w_bd;
    logic [BIT_LEN-1:0] w_x;
    logic [BIT_LEN-1:0] w_y;
    logic [BIT_LEN-1:0] w_xd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FLUSH feeds zeros so the last DELAY b-pairs drain without upstream input.
    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        w_frame_end  = 1'b0;
        w_a          = A_in;
        w_b          = B_in;
        case (r_state)
            c_IDLE: begin
                if (valid_in) begin
                    w_step       = 1'b1;
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (valid_in) begin
                    w_step = 1'b1;
                    if (last_in && (r_cnt == c_CNT_LAST)) begin
                        w_next_state = c_FLUSH;
                    end
                end
            end
            c_FLUSH: begin
                w_step = 1'b1;
                w_a    = '0;
                w_b    = '0;
                if (r_cnt == c_FLUSH_LAST) begin
                    w_frame_end  = 1'b1;
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign ready_out = (r_state != c_FLUSH);
    assign w_sel     = r_cnt[c_SB];
    assign w_bd      = r_bdl[DELAY-1];
    assign w_xd      = r_xdl[DELAY-1];
    assign w_x       = w_sel ? w_bd : w_a;
    assign w_y       = w_sel ? w_a  : w_bd;
    // The first half-group of a frame only fills the delay lines.
    assign w_prime   = r_first && !w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else if (w_step) begin
            if (w_frame_end) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
                if (w_sel) begin
                    r_first <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                r_bdl[i] <= '0;
                r_xdl[i] <= '0;
            end
        end else if (w_step) begin
            r_bdl[0] <= w_b;
            r_xdl[0] <= w_x;
            for (int i = 1; i < DELAY; i++) begin
                r_bdl[i] <= r_bdl[i-1];
                r_xdl[i] <= r_xdl[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            A_out     <= '0;
            B_out     <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= w_step && !w_prime;
            last_out  <= w_frame_end;
            if (w_step) begin
                A_out <= w_xd;
                B_out <= w_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_r2mdc_commutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2mdc_commutator
// Brief    : Scoreboard bench for r2mdc_commutator (DELAY=2 and DELAY=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_r2mdc_commutator;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } pair_t;

    logic        clk;
    logic        reset;
    logic        v0, l0, rdy0, vo0, lo0;
    logic [13:0] a0_in, b0_in, a0_out, b0_out;
    logic        v1, l1, rdy1, vo1, lo1;
    logic [22:0] a1_in, b1_in, a1_out, b1_out;

    pair_t q0[$];
    pair_t q1[$];
    int    fa[64];
    int    fb[64];
    int    n_checks;
    int    n_pass;
    int    last_wait;

    r2mdc_commutator #(.BIT_LEN(14), .DELAY(2)) u_dut0 (
        .clk(clk), .reset(reset), .valid_in(v0), .last_in(l0), .A_in(a0_in), .B_in(b0_in),
        .ready_out(rdy0), .A_out(a0_out), .B_out(b0_out), .valid_out(vo0), .last_out(lo0)
    );

    r2mdc_commutator #(.BIT_LEN(23), .DELAY(1)) u_dut1 (
        .clk(clk), .reset(reset), .valid_in(v1), .last_in(l1), .A_in(a1_in), .B_in(b1_in),
        .ready_out(rdy1), .A_out(a1_out), .B_out(b1_out), .valid_out(vo1), .last_out(lo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        pair_t e;
        if (vo0) begin
            n_checks++;
            if (q0.size() == 0) begin
                $display("FAIL sb0_extra: got A=%0d B=%0d last=%0b, required no output", a0_out, b0_out, lo0);
            end else begin
                e = q0.pop_front();
                if (a0_out !== e.a[13:0] || b0_out !== e.b[13:0] || lo0 !== e.last)
                    $display("FAIL sb0_pair: got A=%0d B=%0d last=%0b, required A=%0d B=%0d last=%0b",
                             a0_out, b0_out, lo0, e.a[13:0], e.b[13:0], e.last);
                else n_pass++;
            end
        end
        if (vo1) begin
            n_checks++;
            if (q1.size() == 0) begin
                $display("FAIL sb1_extra: got A=%h B=%h last=%0b, required no output", a1_out, b1_out, lo1);
            end else begin
                e = q1.pop_front();
                if (a1_out !== e.a[22:0] || b1_out !== e.b[22:0] || lo1 !== e.last)
                    $display("FAIL sb1_pair: got A=%h B=%h last=%0b, required A=%h B=%h last=%0b",
                             a1_out, b1_out, lo1, e.a[22:0], e.b[22:0], e.last);
                else n_pass++;
            end
        end
    end

    task automatic push_pair0(input int a, input int b, input logic last);
        pair_t p;
        p.a = a; p.b = b; p.last = last;
        q0.push_back(p);
    endtask

    // Expected order for DELAY=2: per 4-pair group, a-pairs then b-pairs.
    task automatic push_frame0(input int n);
        for (int g = 0; g < n / 4; g++) begin
            for (int j = 0; j < 2; j++) push_pair0(fa[g*4+j], fa[g*4+j+2], 1'b0);
            for (int j = 0; j < 2; j++) push_pair0(fb[g*4+j], fb[g*4+j+2], (g == n/4 - 1) && (j == 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send0(input int a, input int b, input logic last);
        v0 = 1'b1; l0 = last; a0_in = 14'(a); b0_in = 14'(b);
        last_wait = 0;
        for (int k = 0; k < 20; k++) begin
            if (rdy0) break;
            @(posedge clk); #1;
            last_wait++;
        end
        if (!rdy0) begin
            n_checks++;
            $display("FAIL send0_timeout: ready_out=%0b after 20 cycles, required 1", rdy0);
        end
        @(posedge clk); #1;
        v0 = 1'b0; l0 = 1'b0;
    endtask

    task automatic send1(input int a, input int b, input logic last);
        v1 = 1'b1; l1 = last; a1_in = 23'(a); b1_in = 23'(b);
        for (int k = 0; k < 20; k++) begin
            if (rdy1) break;
            @(posedge clk); #1;
        end
        if (!rdy1) begin
            n_checks++;
            $display("FAIL send1_timeout: ready_out=%0b after 20 cycles, required 1", rdy1);
        end
        @(posedge clk); #1;
        v1 = 1'b0; l1 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 60; k++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk); #1;
        end
        idle(4);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL %s_drain: pending q0=%0d q1=%0d, required 0 0", name, q0.size(), q1.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        n_checks++;
        if (a0_out !== 14'd0 || b0_out !== 14'd0) $display("FAIL rst_data: got A=%0d B=%0d, required 0 0", a0_out, b0_out);
        else n_pass++;
        n_checks++;
        if (vo0 !== 1'b0 || lo0 !== 1'b0) $display("FAIL rst_flags: got valid=%0b last=%0b, required 0 0", vo0, lo0);
        else n_pass++;
        n_checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) $display("FAIL rst_ready: got %0b %0b, required 1 1", rdy0, rdy1);
        else n_pass++;
        n_checks++;
        if (a1_out !== 23'd0 || vo1 !== 1'b0) $display("FAIL rst_dut1: got A=%0d valid=%0b, required 0 0", a1_out, vo1);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin fa[i] = i; fb[i] = 10 + i; end
        push_frame0(4);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                v0 = 1'b1; a0_in = 14'(c); b0_in = 14'(10 + c); l0 = (c == 3);
            end else begin
                v0 = 1'b0; l0 = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (vo0 !== (c >= 3 && c <= 6)) $display("FAIL basic_valid c%0d: got %0b, required %0b", c, vo0, (c >= 3 && c <= 6));
            else n_pass++;
            n_checks++;
            if (lo0 !== (c == 6)) $display("FAIL basic_last c%0d: got %0b, required %0b", c, lo0, (c == 6));
            else n_pass++;
            n_checks++;
            if (rdy0 !== !(c == 4 || c == 5)) $display("FAIL basic_ready c%0d: got %0b, required %0b", c, rdy0, !(c == 4 || c == 5));
            else n_pass++;
            @(posedge clk); #1;
        end
        wait_drain("basic");
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin fa[i] = i; fb[i] = 10 + i; end
        push_frame0(4);
        send0(0, 10, 1'b0); idle(1);
        send0(1, 11, 1'b0); idle(1);
        send0(2, 12, 1'b0);
        send0(3, 13, 1'b1);
        wait_drain("gaps");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin fa[i] = 20 + i; fb[i] = 40 + i; end
        push_frame0(8);
        for (int i = 0; i < 8; i++) send0(fa[i], fb[i], i == 7);
        for (int i = 0; i < 8; i++) begin fa[i] = 60 + i; fb[i] = 80 + i; end
        push_frame0(8);
        send0(fa[0], fb[0], 1'b0);
        n_checks++;
        if (last_wait != 2) $display("FAIL b2b_gap: got %0d stalled cycles, required 2", last_wait);
        else n_pass++;
        for (int i = 1; i < 8; i++) send0(fa[i], fb[i], i == 7);
        wait_drain("b2b");
    endtask

    task automatic test_reset_flush();
        push_pair0(0, 2, 1'b0);
        push_pair0(1, 3, 1'b0);
        for (int i = 0; i < 4; i++) send0(i, 10 + i, i == 3);
        n_checks++;
        if (rdy0 !== 1'b0) $display("FAIL rflush_inflush: got ready=%0b, required 0", rdy0);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a0_out !== 14'd0 || b0_out !== 14'd0 || vo0 !== 1'b0 || lo0 !== 1'b0 || rdy0 !== 1'b1)
            $display("FAIL rflush_clear: got A=%0d B=%0d v=%0b l=%0b rdy=%0b, required 0 0 0 0 1",
                     a0_out, b0_out, vo0, lo0, rdy0);
        else n_pass++;
        reset = 1'b0;
        idle(3);
        for (int i = 0; i < 4; i++) begin fa[i] = 5 + i; fb[i] = 15 + i; end
        push_frame0(4);
        for (int i = 0; i < 4; i++) send0(fa[i], fb[i], i == 3);
        wait_drain("rflush");
    endtask

    task automatic test_delay1_sign();
        pair_t p;
        p.a = -1;      p.b = 8380416; p.last = 1'b0; q1.push_back(p);
        p.a = 8380416; p.b = -1;      p.last = 1'b1; q1.push_back(p);
        send1(-1, 8380416, 1'b0);
        send1(8380416, -1, 1'b1);
        wait_drain("d1");
    endtask

    task automatic test_misaligned_last();
        for (int i = 0; i < 4; i++) begin fa[i] = 30 + i; fb[i] = 50 + i; end
        push_frame0(4);
        send0(30, 50, 1'b0);
        send0(31, 51, 1'b1);
        n_checks++;
        if (rdy0 !== 1'b1) $display("FAIL misalign_ready: got %0b, required 1", rdy0);
        else n_pass++;
        send0(32, 52, 1'b0);
        send0(33, 53, 1'b1);
        wait_drain("misalign");
    endtask

    initial begin
        n_checks = 0; n_pass = 0; last_wait = 0;
        reset = 1'b1;
        v0 = 1'b0; l0 = 1'b0; a0_in = '0; b0_in = '0;
        v1 = 1'b0; l1 = 1'b0; a1_in = '0; b1_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_reset_flush();
        test_delay1_sign();
        test_misaligned_last();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/r2mdc_commutator.md
Name: r2mdc_commutator

Overview:
- Inter-stage delay-commutator for the radix-2 multipath delay commutator NTT pipeline.
- Consumes the A/B pair stream produced by one butterfly stage. Re-pairs the samples so that the next butterfly stage receives operands DELAY positions apart.
- Built from two DELAY-deep delay lines, a toggling switch, and a frame controller. The controller drains the last DELAY pairs of a frame without requiring further input.

Parameters:
- bit_len, 14, width of every data sample (signed two's complement, passed through unmodified).
- DELAY, 2, commutator distance D. Must be a power of two and ≥1. Frame length must be a multiple of 2*DELAY pairs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  A_in/B_in/last_in valid this cycle. Accepted only when ready_out=1.
- last_in  input  1  marks the final pair of a frame. Qualified by an accepted valid_in.
- A_in  input  bit_len  upper-path sample from the preceding butterfly.
- B_in  input  bit_len  lower-path sample from the preceding butterfly.
- ready_out  output  1  block can accept input. Low only during FLUSH.
- A_out  output  bit_len  first operand to the next butterfly.
- B_out  output  bit_len  second operand, DELAY positions later.
- valid_out  output  1  A_out/B_out hold a real pair.
- last_out  output  1  final pair of the frame. Coincides with valid_out.

Behaviour:
- Reset (synchronous, active-high) applies to every output:
  - A_out=0, B_out=0, valid_out=0, last_out=0, ready_out=1.
  - Both delay lines cleared; step counter cnt=0; state IDLE.
  - Reset mid-frame or mid-flush discards all in-flight data. No output pulse follows.
- Step: the internal pipeline advances only on a step.
  - Step occurs on accepted valid_in (RUN/IDLE) or on every cycle in FLUSH.
  - Otherwise all state holds.
- cnt: log2(2*DELAY)-bit counter, incremented each step, wrapping 2*DELAY-1→0.
- sel = cnt[log2(DELAY)]. sel is 0 for the first DELAY steps of each 2*DELAY group and 1 for the rest.
- Datapath per step t, where a = A_in and b = B_in:
  - bd = B delayed DELAY steps.
  - Switch: sel=0 gives x=a, y=bd. sel=1 gives x=bd, y=a.
  - xd = x delayed DELAY steps.
  - Pair (xd, y) is registered into (A_out, B_out) at the end of the step cycle, so output latency is 1 cycle after the step.
- Resulting order, per 2*DELAY-pair group:
  - First emit (a[j], a[j+DELAY]) for j = 0..DELAY-1.
  - Then emit (b[j], b[j+DELAY]) for j = 0..DELAY-1.
  - The b pairs come out during the first DELAY steps of the next group, or during FLUSH.
- valid_out is high for exactly one cycle per step, except for the first DELAY steps of a frame, which are priming steps.
  - Each frame of N input pairs yields exactly N output pairs.
  - With no step, valid_out=0 and A_out/B_out hold their last value.
- States:
  - IDLE: waiting for a frame. First accepted valid_in goes to RUN with cnt=1.
  - RUN: stepping on accepted valid_in. An accepted valid_in with last_in=1 and cnt==2*DELAY-1 goes to FLUSH.
  - FLUSH: ready_out=0. Steps DELAY times with zero fed on A/B to emit the final b pairs. Goes to IDLE after the DELAY-th step. last_out=1 with the valid_out of that final step.
- Boundary conditions:
  - last_in at cnt≠2*DELAY-1 (misaligned frame) is ignored. The sample is still accepted as data.
  - valid_in while ready_out=0 is ignored and not stored. Upstream must hold it.
  - valid_in gaps inside RUN are legal. The pipeline freezes and alignment is preserved.
  - A new frame may start on the cycle ready_out returns high. Back-to-back frames are separated by exactly DELAY cycles.
  - Data is never modified or sign-adjusted.

Test Plan:
- DELAY=2, pairs a=0,1,2,3 and b=10,11,12,13 sent on cycles 0-3 with last_in at cycle 3.
  -> Outputs (0,2) at cycle 3, (1,3) at 4, (10,12) at 5, (11,13) at 6.
  -> valid_out high cycles 3-6; last_out only at 6; ready_out low cycles 4-5.
- Same frame with valid_in dropped at cycles 1 and 3 (data stretched over 6 cycles).
  -> Identical pair sequence; valid_out absent during input gaps.
- Two frames of 8 pairs each, DELAY=2, second frame started the first cycle ready_out=1.
  -> 16 output pairs in the correct (a-pairs, b-pairs) group order; last_out twice.
- reset asserted during FLUSH after (0,2) has been emitted.
  -> Next cycle all outputs 0 and ready_out=1.
  -> A following 4-pair frame with values 5..8/15..18 yields (5,7),(6,8),(15,17),(16,18).
- DELAY=1, bit_len=23, values -1 and 8380416.
  -> Pairs (a0,a1),(b0,b1) bit-exact, no sign corruption.
- last_in asserted at cnt=1 of a 4-pair frame (DELAY=2).
  -> Ignored; block stays in RUN; frame completes at the next aligned last_in.
